stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the 4-digit BCD stopwatch counter. Conditions raw push-buttons (synchronise, debounce, edge-detect) and generates the counting tick from a prescaler. Runs the IDLE/RUN/PAUSE/DONE state machine and drives the counter's clear, load, direction and count-enable. Sits between board buttons/switches and the counter datapath; the counter's digit outputs feed back for terminal-count detection.

Parameters:
TICK_DIV, 1000000, clk cycles per count tick (100 MHz clock -> 10 ms ticks)
DB_CYCLES, 500000, cycles a synchronised button must be stable before its debounced level changes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_start  in  1  raw start/stop button, asynchronous
btn_clear  in  1  raw clear button, asynchronous
sw_down  in  1  direction switch: 1 = count down, 0 = count up
sw_load  in  1  1 = clear loads sw_value into upper digits
sw_value  in  8  two BCD digits for the upper counter digits
cnt_digits  in  16  counter digits {s3,s2,s1,s0}, 4 bits each
btn_lap  in  1  raw lap button (used only with LAP_EN)
cnt_en  out  1  one-cycle count strobe to the counter
cnt_clr  out  1  one-cycle clear strobe to the counter
cnt_load  out  1  qualifies cnt_clr: load load_value instead of zero
load_value  out  8  clamped BCD load value
decrement  out  1  latched count direction
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
expired  out  1  high while in DONE
disp_freeze  out  1  display hold (LAP_EN only)

Behaviour:
- Reset: state=IDLE; prescaler=0; debouncers and edge registers 0. All outputs 0.
- Button path, per button: 2-flop synchroniser -> debouncer -> rising-edge detector.
  - Debounced level changes only after DB_CYCLES consecutive cycles of a differing synchronised value.
  - Press pulse is one cycle wide on the debounced rising edge.
  - Press latency is 2 + DB_CYCLES + 1 cycles after the raw edge.
- load_value is registered each cycle from sw_value. Each nibble above 9 is clamped to 9 (0xA3 -> 0x93).
- decrement samples sw_down only in IDLE. It is held constant in RUN, PAUSE and DONE.
- Terminal flags:
  - zero = cnt_digits==16'h0000.
  - max = cnt_digits==16'h9999.
  - term = decrement ? zero : max.
- Prescaler:
  - Increments only in RUN and wraps at TICK_DIV-1.
  - tick = RUN && prescaler==TICK_DIV-1.
  - Holds its value in PAUSE, so the partial interval is kept.
  - Cleared to 0 by a clear press.
- cnt_en = tick && !term.
- Clear press, any state:
  - Next state is IDLE.
  - cnt_clr=1 for one cycle, with cnt_load=sw_load in the same cycle.
  - Prescaler returns to 0.
  - Clear has priority over a start press or term in the same cycle.
- IDLE:
  - Start press with term=0 -> RUN.
  - Start press with term=1 (e.g. count-down from 0000) is ignored; stay in IDLE.
- RUN:
  - Start press -> PAUSE.
  - term=1 -> DONE in the following cycle (counter saturated at 0000 or 9999).
  - Start press and term in the same cycle -> DONE.
- PAUSE: start press -> RUN. cnt_en stays 0.
- DONE: expired=1. Start presses are ignored; only clear or reset exits.
- Reset during RUN/PAUSE: next cycle is the reset state. cnt_clr is not asserted; the counter has its own reset.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- Defined:
  - btn_lap is conditioned like the other buttons.
  - In RUN or PAUSE, a lap press toggles disp_freeze.
  - Entering IDLE or DONE forces disp_freeze=0.
  - Counting is unaffected.
- Undefined: btn_lap is ignored, no lap logic is built, and disp_freeze is tied 0.

Test Plan:
All scenarios use TICK_DIV=4, DB_CYCLES=3.
1. Bouncy start: raw btn_start toggles 1,0,1 then holds 1 for 10 cycles -> exactly one press pulse, 6 cycles after the stable edge. state 0->1.
2. Up count: in RUN with cnt_digits=0x0000 -> cnt_en pulses every 4th cycle. Start press -> PAUSE with cnt_en=0. Second press -> RUN, and the next tick arrives after the remaining prescaler count only.
3. Load and clamp: sw_load=1, sw_value=0xF5, clear press -> cnt_clr=1, cnt_load=1 for one cycle, load_value=0x95, state=IDLE.
4. Countdown expiry: sw_down=1, start, cnt_digits reaches 0x0000 -> no further cnt_en, state=DONE, expired=1. Start press ignored; clear -> IDLE.
5. Priority: start and clear pulses in the same cycle while in RUN -> IDLE, cnt_clr=1. Start in IDLE with sw_down=1 and digits 0x0000 -> stays IDLE.
6. LAP_EN build: lap press in RUN -> disp_freeze=1 while cnt_en continues. Second lap press -> 0. Clear -> 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control sequencer (lap/display-freeze option: STOPWATCH_LAP_EN)
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        sw_down,
  input  logic        sw_load,
  input  logic [7:0]  sw_value,
  input  logic [15:0] cnt_digits,
  input  logic        btn_lap,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        cnt_load,
  output logic [7:0]  load_value,
  output logic        decrement,
  output logic [1:0]  state,
  output logic        expired,
  output logic        disp_freeze
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int BTN_LAP = 2;
  localparam int NB      = 3;
`else
  localparam int NB      = 2;
`endif

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

  logic [NB-1:0]  btn_raw;
  logic [NB-1:0]  sync_a;
  logic [NB-1:0]  sync_b;
  logic [NB-1:0]  db_lvl;
  logic [NB-1:0]  db_lvl_d;
  logic [NB-1:0]  press;
  logic [DBW-1:0] db_cnt [NB];

  state_t         state_q;
  state_t         state_next;
  logic [TW-1:0]  presc;
  logic           start_press;
  logic           clear_press;
  logic           cnt_zero;
  logic           cnt_max;
  logic           term;
  logic           tick;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
  assign btn_raw = {btn_clear, btn_start};
  logic unused_lap;
  assign unused_lap = btn_lap;
`endif

  // Per button: two-flop synchroniser, stability-counting debouncer, registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      press    <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      db_lvl_d <= db_lvl;
      press    <= db_lvl & ~db_lvl_d;
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign start_press = press[BTN_START];
  assign clear_press = press[BTN_CLEAR];

  assign cnt_zero = (cnt_digits == 16'h0000);
  assign cnt_max  = (cnt_digits == 16'h9999);
  assign term     = decrement ? cnt_zero : cnt_max;
  assign tick     = (state_q == RUN) && (presc == TICK_LAST);

  // Next-state logic: clear wins over everything, saturation wins over a start press in RUN
  always_comb begin
    state_next = state_q;
    if (clear_press) begin
      state_next = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_press && !term) state_next = RUN;
        RUN:     if (term) state_next = DONE;
                 else if (start_press) state_next = PAUSE;
        PAUSE:   if (start_press) state_next = RUN;
        default: state_next = DONE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Prescaler advances only while running, so a pause keeps the partial interval
  always_ff @(posedge clk) begin
    if (reset || clear_press) begin
      presc <= '0;
    end else if (state_q == RUN) begin
      presc <= (presc == TICK_LAST) ? '0 : presc + TW'(1);
    end
  end

  // Direction latches only while idle; load value is re-sampled and clamped to BCD every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      decrement  <= 1'b0;
      load_value <= 8'h00;
    end else begin
      if (state_q == IDLE) decrement <= sw_down;
      load_value <= {(sw_value[7:4] > 4'd9) ? 4'd9 : sw_value[7:4],
                     (sw_value[3:0] > 4'd9) ? 4'd9 : sw_value[3:0]};
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap press toggles the display hold while timing; leaving for IDLE or DONE releases it
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_freeze <= 1'b0;
    end else if (state_next == IDLE || state_next == DONE) begin
      disp_freeze <= 1'b0;
    end else if (press[BTN_LAP] && (state_q == RUN || state_q == PAUSE)) begin
      disp_freeze <= ~disp_freeze;
    end
  end
`else
  assign disp_freeze = 1'b0;
`endif

  assign cnt_en   = tick && !term;
  assign cnt_clr  = clear_press;
  assign cnt_load = clear_press && sw_load;
  assign state    = state_q;
  assign expired  = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed scoreboard bench for stopwatch_ctrl (TICK_DIV=4, DB_CYCLES=3)
module tb_stopwatch_ctrl;

  localparam int S_STATE = 0;
  localparam int S_EN    = 1;
  localparam int S_CLR   = 2;
  localparam int S_LOAD  = 3;
  localparam int S_LV    = 4;
  localparam int S_DEC   = 5;
  localparam int S_EXP   = 6;
  localparam int S_FRZ   = 7;

  localparam logic [15:0] ST_IDLE  = 16'd0;
  localparam logic [15:0] ST_RUN   = 16'd1;
  localparam logic [15:0] ST_PAUSE = 16'd2;
  localparam logic [15:0] ST_DONE  = 16'd3;

`ifdef STOPWATCH_LAP_EN
  localparam logic [15:0] LAP_ON = 16'd1;
`else
  localparam logic [15:0] LAP_ON = 16'd0;
`endif

  logic        clk;
  logic        reset;
  logic        btn_start;
  logic        btn_clear;
  logic        sw_down;
  logic        sw_load;
  logic [7:0]  sw_value;
  logic [15:0] cnt_digits;
  logic        btn_lap;
  logic        cnt_en;
  logic        cnt_clr;
  logic        cnt_load;
  logic [7:0]  load_value;
  logic        decrement;
  logic [1:0]  state;
  logic        expired;
  logic        disp_freeze;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .sw_down    (sw_down),
    .sw_load    (sw_load),
    .sw_value   (sw_value),
    .cnt_digits (cnt_digits),
    .btn_lap    (btn_lap),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .cnt_load   (cnt_load),
    .load_value (load_value),
    .decrement  (decrement),
    .state      (state),
    .expired    (expired),
    .disp_freeze(disp_freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input int sig, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      S_STATE: observe = {14'd0, state};
      S_EN:    observe = {15'd0, cnt_en};
      S_CLR:   observe = {15'd0, cnt_clr};
      S_LOAD:  observe = {15'd0, cnt_load};
      S_LV:    observe = {8'd0, load_value};
      S_DEC:   observe = {15'd0, decrement};
      S_EXP:   observe = {15'd0, expired};
      S_FRZ:   observe = {15'd0, disp_freeze};
      default: observe = 16'hxxxx;
    endcase
  endfunction

  task automatic check_sb();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    cyc();
    check_sb();
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_start = v;
      1:       btn_clear = v;
      default: btn_lap   = v;
    endcase
  endtask

  // Holds the raw button until the cycle its press pulse is live, then releases it
  task automatic press_btn(input int which);
    set_btn(which, 1'b1);
    repeat (6) cyc();
    set_btn(which, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    btn_start  = 1'b0;
    btn_clear  = 1'b0;
    btn_lap    = 1'b0;
    sw_down    = 1'b0;
    sw_load    = 1'b0;
    sw_value   = 8'hA3;
    cnt_digits = 16'h0000;
    repeat (3) cyc();

    want("rst_state", S_STATE, ST_IDLE);
    want("rst_en",    S_EN,    16'd0);
    want("rst_clr",   S_CLR,   16'd0);
    want("rst_load",  S_LOAD,  16'd0);
    want("rst_lv",    S_LV,    16'd0);
    want("rst_dec",   S_DEC,   16'd0);
    want("rst_exp",   S_EXP,   16'd0);
    want("rst_frz",   S_FRZ,   16'd0);
    check_sb();

    reset = 1'b0;
    want("clamp_a3", S_LV, 16'h0093);
    step();

    // Bouncy start: 1,0 glitch then a stable high
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    cyc();
    btn_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      want("bounce_idle", S_STATE, ST_IDLE);
      step();
    end
    want("bounce_run", S_STATE, ST_RUN);
    step();

    // Up count from 0000: tick every 4th cycle, one press only despite the long hold
    for (int j = 1; j <= 10; j++) begin
      if (j == 3) btn_start = 1'b0;
      want("up_en",  S_EN,    16'((j % 4) == 3));
      want("up_run", S_STATE, ST_RUN);
      step();
    end

    press_btn(0);
    want("pause_pre", S_STATE, ST_RUN);
    check_sb();
    want("pause_st", S_STATE, ST_PAUSE);
    want("pause_en", S_EN, 16'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      want("pause_hold", S_STATE, ST_PAUSE);
      want("pause_en",   S_EN,    16'd0);
      step();
    end

    press_btn(0);
    want("resume_pre", S_STATE, ST_PAUSE);
    check_sb();
    want("resume_st", S_STATE, ST_RUN);
    want("resume_en", S_EN, 16'd0);
    step();
    for (int k = 1; k <= 6; k++) begin
      want("resume_tick", S_EN, 16'(k == 2 || k == 6));
      step();
    end

    // Clear with load and clamp
    sw_load  = 1'b1;
    sw_value = 8'hF5;
    want("clamp_f5", S_LV, 16'h0095);
    step();
    press_btn(1);
    want("ld_clr",   S_CLR,   16'd1);
    want("ld_load",  S_LOAD,  16'd1);
    want("ld_lv",    S_LV,    16'h0095);
    want("ld_state", S_STATE, ST_RUN);
    check_sb();
    want("ld_idle",  S_STATE, ST_IDLE);
    want("ld_clr0",  S_CLR,   16'd0);
    want("ld_load0", S_LOAD,  16'd0);
    step();

    // Countdown to expiry
    sw_load    = 1'b0;
    sw_down    = 1'b1;
    cnt_digits = 16'h0001;
    want("dn_dec",  S_DEC,   16'd1);
    want("dn_idle", S_STATE, ST_IDLE);
    step();
    press_btn(0);
    want("dn_pre", S_STATE, ST_IDLE);
    check_sb();
    want("dn_run", S_STATE, ST_RUN);
    step();
    for (int j = 1; j <= 4; j++) begin
      want("dn_en",  S_EN,    16'(j == 3));
      want("dn_st",  S_STATE, ST_RUN);
      step();
    end
    cnt_digits = 16'h0000;
    want("done_st",  S_STATE, ST_DONE);
    want("done_exp", S_EXP,   16'd1);
    want("done_en",  S_EN,    16'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      want("done_hold", S_STATE, ST_DONE);
      want("done_en",   S_EN,    16'd0);
      step();
    end
    press_btn(0);
    want("done_ign", S_STATE, ST_DONE);
    want("done_dec", S_DEC,   16'd1);
    step();
    press_btn(1);
    want("done_clr",   S_CLR,   16'd1);
    want("done_load0", S_LOAD,  16'd0);
    want("done_pre",   S_STATE, ST_DONE);
    want("done_exp1",  S_EXP,   16'd1);
    check_sb();
    want("done_idle", S_STATE, ST_IDLE);
    want("done_exp0", S_EXP,   16'd0);
    want("done_clr0", S_CLR,   16'd0);
    step();

    // Start ignored in IDLE when already at terminal count
    press_btn(0);
    want("term_pre", S_STATE, ST_IDLE);
    check_sb();
    want("term_ign", S_STATE, ST_IDLE);
    step();
    sw_down = 1'b0;
    want("up_dec", S_DEC, 16'd0);
    step();
    repeat (6) cyc();
    press_btn(0);
    want("prio_run", S_STATE, ST_RUN);
    step();
    repeat (6) cyc();

    // Start and clear in the same cycle: clear wins
    btn_start = 1'b1;
    btn_clear = 1'b1;
    repeat (6) cyc();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    want("prio_clr",  S_CLR,   16'd1);
    want("prio_pre",  S_STATE, ST_RUN);
    check_sb();
    want("prio_idle", S_STATE, ST_IDLE);
    want("prio_clr0", S_CLR,   16'd0);
    step();

    // Lap freeze (held at 0 when the option is not built)
    repeat (6) cyc();
    press_btn(0);
    want("lap_run",  S_STATE, ST_RUN);
    want("lap_frz0", S_FRZ,   16'd0);
    step();
    press_btn(2);
    want("lap_pre", S_FRZ, 16'd0);
    check_sb();
    want("lap_on", S_FRZ, LAP_ON);
    step();
    pulses = 0;
    repeat (8) begin
      cyc();
      pulses += int'(cnt_en);
    end
    checks++;
    assert (pulses === 2) else begin
      errors++;
      $error("FAIL lap_count observed %0d expected %0d", pulses, 2);
    end
    want("lap_still", S_FRZ, LAP_ON);
    check_sb();
    press_btn(2);
    want("lap_off", S_FRZ, 16'd0);
    step();
    repeat (6) cyc();
    press_btn(2);
    want("lap_on2", S_FRZ, LAP_ON);
    step();
    repeat (2) cyc();
    press_btn(1);
    want("lap_clr_pre", S_FRZ, LAP_ON);
    check_sb();
    want("lap_clr",  S_FRZ,   16'd0);
    want("lap_idle", S_STATE, ST_IDLE);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
